matrix_operand_memory: RTL and testbench

MATRIX_OPERAND_MEMORY -- requirements
Module: matrix_operand_memory

---
 rtl/matrix_operand_memory.sv | 171 +++++++++++++++++
 tb/tb_matrix_operand_memory.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_memory.sv
// Operand store for a small matrix-vector engine: W matrix, X vector and
// accumulator vector, with a command/response port and a serial MAC sequencer.
module matrix_operand_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int MAT_DIM    = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAT_DIM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_we,
    input  logic [DATA_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [ACC_WIDTH-1:0]  rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);
    // state   | meaning
    // IDLE    | accepting commands; in-range writes complete here
    // COMPUTE | one MAC per cycle, row-major over W
    // RESP    | response held until rsp_rdy
    localparam int NW = MAT_DIM*MAT_DIM;
    localparam int XW = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [1:0] OP_W = 2'd0, OP_X = 2'd1, OP_C = 2'd2, OP_A = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESP} state_t;
    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] w_q   [NW];
    logic signed [DATA_WIDTH-1:0] x_q   [MAT_DIM];
    logic signed [ACC_WIDTH-1:0]  acc_q [MAT_DIM];

    logic                 ready_q;
    logic                 rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
    logic [ACC_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [XW-1:0]        row_q, row_d, col_q, col_d;
    logic [WW-1:0]        cnt_q, cnt_d;

    logic                          accept, addr_ok, do_write;
    logic [WW-1:0]                 w_idx, mac_widx;
    logic [XW-1:0]                 x_idx;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   mac_sum, rd_val;

    assign cmd_rdy  = ready_q && (state_q == S_IDLE) && !rsp_vld_q;
    assign busy     = (state_q == S_COMPUTE);
    assign rsp_vld  = rsp_vld_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_data = rsp_data_q;

    assign accept   = cmd_vld && cmd_rdy;
    assign w_idx    = cmd_addr[WW-1:0];
    assign x_idx    = cmd_addr[XW-1:0];
    assign addr_ok  = (cmd_op == OP_W) ? (cmd_addr < DATA_WIDTH'(NW))
                                       : (cmd_addr < DATA_WIDTH'(MAT_DIM));
    assign do_write = accept && cmd_we && (cmd_op != OP_C) && addr_ok;

    // cnt_q runs NW-1 down to 0, so the row-major W index is its complement.
    assign mac_widx = WW'(NW-1) - cnt_q;
    assign prod     = w_q[mac_widx] * x_q[col_q];
    assign mac_sum  = acc_q[row_q] + ACC_WIDTH'(prod);

    always_comb begin
        rd_val = '0;
        case (cmd_op)
            OP_W:    rd_val = ACC_WIDTH'(w_q[w_idx]);
            OP_X:    rd_val = ACC_WIDTH'(x_q[x_idx]);
            OP_A:    rd_val = acc_q[x_idx];
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_C) begin
                        state_d = S_COMPUTE;
                        row_d   = '0;
                        col_d   = '0;
                        cnt_d   = WW'(NW-1);
                    end else if (!cmd_we || !addr_ok) begin
                        state_d    = S_RESP;
                        rsp_vld_d  = 1'b1;
                        rsp_err_d  = !addr_ok;
                        rsp_data_d = addr_ok ? rd_val : '0;
                    end
                end
            end
            S_COMPUTE: begin
                if (col_q == XW'(MAT_DIM-1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d    = S_RESP;
                    rsp_vld_d  = 1'b1;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = mac_sum;
                end
            end
            S_RESP: begin
                if (rsp_rdy) begin
                    state_d   = S_IDLE;
                    rsp_vld_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
            for (int i = 0; i < MAT_DIM; i++) begin
                x_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            if (do_write) begin
                case (cmd_op)
                    OP_W:    w_q[w_idx]   <= cmd_data;
                    OP_X:    x_q[x_idx]   <= cmd_data;
                    OP_A:    acc_q[x_idx] <= ACC_WIDTH'($signed(cmd_data));
                    default: ;
                endcase
            end
            if (accept && (cmd_op == OP_C) && !cmd_data[0]) begin
                for (int i = 0; i < MAT_DIM; i++) acc_q[i] <= '0;
            end
            if (state_q == S_COMPUTE) acc_q[row_q] <= mac_sum;
        end
    end
endmodule

// File: tb/tb_matrix_operand_memory.sv
// Directed bench for matrix_operand_memory: load/read, MAC sequencing,
// range errors, response backpressure and mid-compute reset.
module tb_matrix_operand_memory;
    localparam logic [1:0] OP_W = 2'd0, OP_X = 2'd1, OP_C = 2'd2, OP_A = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_op = '0;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b1;
    logic [33:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    matrix_operand_memory dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a command and returns 1 time unit after the accept edge.
    task automatic send(input logic [1:0] op, input logic we, input logic [15:0] addr,
                        input logic [15:0] data);
        int n;
        @(negedge clk);
        cmd_vld = 1'b1; cmd_op = op; cmd_we = we; cmd_addr = addr; cmd_data = data;
        n = 0;
        while (!cmd_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [1:0] op, input logic [15:0] addr,
                      input logic [15:0] data);
        send(op, 1'b1, addr, data);
        chk({tag, "_norsp"}, 64'(rsp_vld), 64'd0);
    endtask

    task automatic rd(input string tag, input logic [1:0] op, input logic [15:0] addr,
                      input logic [63:0] exp_data, input logic exp_err);
        send(op, 1'b0, addr, 16'd0);
        chk({tag, "_vld"}, 64'(rsp_vld), 64'd1);
        chk({tag, "_data"}, 64'(rsp_data), exp_data);
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic compute(input string tag, input logic mode, input logic [63:0] exp_data);
        int n;
        send(OP_C, 1'b0, 16'd0, {15'd0, mode});
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd16);
        chk({tag, "_vld"}, 64'(rsp_vld), 64'd1);
        chk({tag, "_data"}, 64'(rsp_data), exp_data);
        chk({tag, "_err"}, 64'(rsp_err), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld", 64'(rsp_vld), 64'd0);
        chk("rst_rdy", 64'(cmd_rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", 64'(cmd_rdy), 64'd1);

        wr("w5", OP_W, 16'd5, 16'd7);
        rd("rd_w5", OP_W, 16'd5, 64'd7, 1'b0);

        for (int i = 0; i < 16; i++) wr("w_id", OP_W, 16'(i), (i % 5 == 0) ? 16'd1 : 16'd0);
        for (int i = 0; i < 4; i++) wr("x", OP_X, 16'(i), 16'(i + 1));

        compute("mac0", 1'b0, 64'd4);
        for (int i = 0; i < 4; i++) rd("acc_m0", OP_A, 16'(i), 64'(i + 1), 1'b0);
        compute("mac1", 1'b1, 64'd8);
        for (int i = 0; i < 4; i++) rd("acc_m1", OP_A, 16'(i), 64'(2 * (i + 1)), 1'b0);

        send(OP_X, 1'b1, 16'd4, 16'd55);
        chk("x4_wr_vld", 64'(rsp_vld), 64'd1);
        chk("x4_wr_err", 64'(rsp_err), 64'd1);
        chk("x4_wr_data", 64'(rsp_data), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) rd("x_after_err", OP_X, 16'(i), 64'(i + 1), 1'b0);
        rd("w16_oor", OP_W, 16'd16, 64'd0, 1'b1);
        rd("w15_edge", OP_W, 16'd15, 64'd1, 1'b0);

        wr("w5_neg", OP_W, 16'd5, 16'hFFFE);
        rd("rd_w5_neg", OP_W, 16'd5, 64'h3_FFFF_FFFE, 1'b0);
        compute("mac_neg", 1'b0, 64'd4);
        rd("acc1_neg", OP_A, 16'd1, 64'h3_FFFF_FFFC, 1'b0);
        wr("acc2", OP_A, 16'd2, 16'd5);
        rd("rd_acc2", OP_A, 16'd2, 64'd5, 1'b0);

        rsp_rdy = 1'b0;
        send(OP_W, 1'b0, 16'd0, 16'd0);
        chk("bp_vld0", 64'(rsp_vld), 64'd1);
        chk("bp_data0", 64'(rsp_data), 64'd1);
        cmd_vld = 1'b1; cmd_op = OP_W; cmd_we = 1'b1; cmd_addr = 16'd0; cmd_data = 16'd99;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_vld", 64'(rsp_vld), 64'd1);
            chk("bp_data", 64'(rsp_data), 64'd1);
            chk("bp_err", 64'(rsp_err), 64'd0);
            chk("bp_rdy", 64'(cmd_rdy), 64'd0);
        end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_vld_clr", 64'(rsp_vld), 64'd0);
        chk("bp_rdy_back", 64'(cmd_rdy), 64'd1);
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        chk("bp_wr_norsp", 64'(rsp_vld), 64'd0);
        rd("bp_w0", OP_W, 16'd0, 64'd99, 1'b0);

        send(OP_C, 1'b0, 16'd0, 16'd0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_vld", 64'(rsp_vld), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_rdy", 64'(cmd_rdy), 64'd0);
        chk("mrst_data", 64'(rsp_data), 64'd0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_rdy_back", 64'(cmd_rdy), 64'd1);
        chk("mrst_no_rsp", 64'(rsp_vld), 64'd0);
        rd("mrst_w0", OP_W, 16'd0, 64'd0, 1'b0);
        rd("mrst_w15", OP_W, 16'd15, 64'd0, 1'b0);
        rd("mrst_x3", OP_X, 16'd3, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) rd("mrst_acc", OP_A, 16'(i), 64'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
